instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/isa_pkg.sv | 54 +++++
 rtl/instruction_decoder_if.sv | 35 +++
 rtl/instruction_decoder_decode_table.sv | 62 ++++++
 rtl/instruction_decoder.sv | 111 +++++++++++
 tb/tb_instruction_decoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, ALU operation codes, decoder FSM states
// and the registered control bundle.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_LDI   = 4'h8,
        OP_LD    = 4'h9,
        OP_ST    = 4'hA,
        OP_JMP   = 4'hB,
        OP_BEQ   = 4'hC,
        OP_ILL_D = 4'hD,
        OP_HLT   = 4'hE,
        OP_ILL_F = 4'hF
    } opcode_e;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } state_e;

    // One cycle worth of datapath control; all-zero is a bubble.
    typedef struct packed {
        logic       ar;
        logic       br;
        logic [3:0] alu;
        logic       imm_sel;
        logic       wren;
        logic [2:0] wr_addr;
        logic       write;
        logic       adr_mux;
        logic       pc_load;
        logic       valid;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instruction_decoder_if.sv
// Instruction/control bus between the fetch side and the decoder.
interface instruction_decoder_if;
    logic [15:0] INST_IN;
    logic        INST_VALID_IN;
    logic        READY_OUT;
    logic        STALL_IN;
    logic        FLUSH_IN;
    logic        ZERO_IN;
    logic        AR_OUT;
    logic        BR_OUT;
    logic [3:0]  ALU_OUT;
    logic        input_OUT;
    logic        wren_OUT;
    logic [2:0]  writeAd_OUT;
    logic        write_OUT;
    logic        ADR_MUX_OUT;
    logic        PC_load_OUT;
    logic        VALID_OUT;
    logic        ILLEGAL_OUT;
    logic        HALTED_OUT;

    modport master (
        output INST_IN, INST_VALID_IN, STALL_IN, FLUSH_IN, ZERO_IN,
        input  READY_OUT, AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT,
               writeAd_OUT, write_OUT, ADR_MUX_OUT, PC_load_OUT,
               VALID_OUT, ILLEGAL_OUT, HALTED_OUT
    );

    modport slave (
        input  INST_IN, INST_VALID_IN, STALL_IN, FLUSH_IN, ZERO_IN,
        output READY_OUT, AR_OUT, BR_OUT, ALU_OUT, input_OUT, wren_OUT,
               writeAd_OUT, write_OUT, ADR_MUX_OUT, PC_load_OUT,
               VALID_OUT, ILLEGAL_OUT, HALTED_OUT
    );
endinterface

// File: rtl/instruction_decoder_decode_table.sv
// Combinational opcode -> control table for a freshly accepted instruction.
// For LD this is only the first (address) cycle; the write-back cycle is
// produced by the FSM in the top level.
module decode_table
    import isa_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] rd,
    input  logic       zero,
    output ctrl_t      ctrl,
    output logic       is_ld,
    output logic       is_halt
);

    // Decode one instruction into its first-cycle control word.
    always_comb begin
        ctrl       = '0;
        ctrl.valid = 1'b1;
        is_ld      = 1'b0;
        is_halt    = 1'b0;
        case (opcode_e'(opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                ctrl.ar      = 1'b1;
                ctrl.br      = 1'b1;
                ctrl.write   = 1'b1;
                ctrl.wr_addr = rd;
                case (opcode_e'(opcode))
                    OP_ADD:  ctrl.alu = ALU_ADD;
                    OP_SUB:  ctrl.alu = ALU_SUB;
                    OP_AND:  ctrl.alu = ALU_AND;
                    OP_OR:   ctrl.alu = ALU_OR;
                    OP_XOR:  ctrl.alu = ALU_XOR;
                    OP_SHL:  ctrl.alu = ALU_SHL;
                    default: ctrl.alu = ALU_SHR;
                endcase
            end
            OP_LDI: begin
                ctrl.imm_sel = 1'b1;
                ctrl.write   = 1'b1;
                ctrl.wr_addr = rd;
                ctrl.alu     = ALU_NONE;
            end
            OP_LD: begin
                ctrl.ar      = 1'b1;
                ctrl.adr_mux = 1'b1;
                is_ld        = 1'b1;
            end
            OP_ST: begin
                ctrl.ar      = 1'b1;
                ctrl.br      = 1'b1;
                ctrl.adr_mux = 1'b1;
                ctrl.wren    = 1'b1;
            end
            OP_JMP:  ctrl.pc_load = 1'b1;
            OP_BEQ:  ctrl.pc_load = zero;
            OP_HLT:  is_halt = 1'b1;
            OP_NOP:  ctrl.valid = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: accept handshake, RUN/LDWAIT/HALT sequencing and the
// registered control outputs. Priority is reset > flush > stall > accept.
module instruction_decoder
    import isa_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    instruction_decoder_if.slave  bus
);

    state_e     state;
    state_e     state_nx;
    ctrl_t      out_q;
    ctrl_t      out_nx;
    logic [2:0] ld_rd;
    logic [2:0] ld_rd_nx;
    ctrl_t      dec_ctrl;
    logic       dec_is_ld;
    logic       dec_is_halt;
    logic       ready;
    logic       accept;
    logic       unused_operands;

    // Register operand fields are consumed by the datapath, not the decoder.
    assign unused_operands = ^bus.INST_IN[8:0];

    decode_table u_decode_table (
        .opcode  (bus.INST_IN[15:12]),
        .rd      (bus.INST_IN[11:9]),
        .zero    (bus.ZERO_IN),
        .ctrl    (dec_ctrl),
        .is_ld   (dec_is_ld),
        .is_halt (dec_is_halt)
    );

    assign ready  = (state == ST_RUN) && !bus.STALL_IN;
    assign accept = bus.INST_VALID_IN && ready;

    // Next state and next control word, applying flush/stall priority.
    always_comb begin
        state_nx = state;
        out_nx   = out_q;
        ld_rd_nx = ld_rd;
        if (bus.FLUSH_IN) begin
            out_nx = '0;
            if (state == ST_LDWAIT) begin
                state_nx = ST_RUN;
            end
        end else if (bus.STALL_IN) begin
            // Everything holds except the illegal pulse, which must not repeat.
            out_nx.illegal = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        out_nx = dec_ctrl;
                        if (dec_is_ld) begin
                            state_nx = ST_LDWAIT;
                            ld_rd_nx = bus.INST_IN[11:9];
                        end else if (dec_is_halt) begin
                            state_nx = ST_HALT;
                        end
                    end else begin
                        out_nx = '0;
                    end
                end
                ST_LDWAIT: begin
                    out_nx         = '0;
                    out_nx.adr_mux = 1'b1;
                    out_nx.write   = 1'b1;
                    out_nx.wr_addr = ld_rd;
                    out_nx.valid   = 1'b1;
                    state_nx       = ST_RUN;
                end
                ST_HALT: out_nx = '0;
                default: begin
                    out_nx   = '0;
                    state_nx = ST_RUN;
                end
            endcase
        end
    end

    // State, pending LD destination and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_RUN;
            out_q <= '0;
            ld_rd <= '0;
        end else begin
            state <= state_nx;
            out_q <= out_nx;
            ld_rd <= ld_rd_nx;
        end
    end

    assign bus.READY_OUT   = ready;
    assign bus.AR_OUT      = out_q.ar;
    assign bus.BR_OUT      = out_q.br;
    assign bus.ALU_OUT     = out_q.alu;
    assign bus.input_OUT   = out_q.imm_sel;
    assign bus.wren_OUT    = out_q.wren;
    assign bus.writeAd_OUT = out_q.wr_addr;
    assign bus.write_OUT   = out_q.write;
    assign bus.ADR_MUX_OUT = out_q.adr_mux;
    assign bus.PC_load_OUT = out_q.pc_load;
    assign bus.VALID_OUT   = out_q.valid;
    assign bus.ILLEGAL_OUT = out_q.illegal;
    assign bus.HALTED_OUT  = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_instruction_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_decoder_if bus();

    instruction_decoder dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_wr   = 0;

    // Model: halted flag, pending LD destination (-1 = none), expected word.
    // Word layout: ar br alu[4] imm wren wad[3] wr adr pc valid ill halted
    bit          m_halt  = 1'b0;
    int          m_ld_rd = -1;
    logic [16:0] m_exp   = '0;

    function automatic logic [16:0] ctl(input bit ar, input bit br, input int alu,
                                        input bit imm, input bit wren, input int wad,
                                        input bit wr, input bit adr, input bit pc,
                                        input bit valid, input bit ill);
        logic [3:0] a4;
        logic [2:0] w3;
        a4 = alu[3:0];
        w3 = wad[2:0];
        return {ar, br, a4, imm, wren, w3, wr, adr, pc, valid, ill, 1'b0};
    endfunction

    function automatic logic [16:0] dut_word();
        return {bus.AR_OUT, bus.BR_OUT, bus.ALU_OUT, bus.input_OUT, bus.wren_OUT,
                bus.writeAd_OUT, bus.write_OUT, bus.ADR_MUX_OUT, bus.PC_load_OUT,
                bus.VALID_OUT, bus.ILLEGAL_OUT, bus.HALTED_OUT};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit stall);
        return !m_halt && (m_ld_rd < 0) && !stall;
    endfunction

    task automatic model_step(input logic [15:0] inst, input bit v, input bit s,
                              input bit f, input bit z);
        int op;
        int rd;
        op = int'(inst[15:12]);
        rd = int'(inst[11:9]);
        if (f) begin
            m_exp   = '0;
            m_ld_rd = -1;
        end else if (s) begin
            m_exp[1] = 1'b0;
        end else if (m_ld_rd >= 0) begin
            m_exp   = ctl(0, 0, 0, 0, 0, m_ld_rd, 1, 1, 0, 1, 0);
            m_ld_rd = -1;
        end else if (m_halt || !v) begin
            m_exp = '0;
        end else begin
            if (op >= 1 && op <= 7)   m_exp = ctl(1, 1, op, 0, 0, rd, 1, 0, 0, 1, 0);
            else if (op == 8)         m_exp = ctl(0, 0, 0, 1, 0, rd, 1, 0, 0, 1, 0);
            else if (op == 9) begin
                m_exp   = ctl(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
                m_ld_rd = rd;
            end
            else if (op == 10)        m_exp = ctl(1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0);
            else if (op == 11)        m_exp = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            else if (op == 12)        m_exp = ctl(0, 0, 0, 0, 0, 0, 0, 0, z, 1, 0);
            else if (op == 14) begin
                m_exp  = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                m_halt = 1'b1;
            end
            else if (op == 13 || op == 15) m_exp = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            else                      m_exp = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        m_exp[0] = m_halt;
    endtask

    // One clock: drive at the falling edge, check READY, step the model,
    // then compare registered outputs at the next falling edge.
    task automatic cycle(input logic [15:0] inst, input bit v, input bit s,
                         input bit f, input bit z);
        bus.INST_IN       = inst;
        bus.INST_VALID_IN = v;
        bus.STALL_IN      = s;
        bus.FLUSH_IN      = f;
        bus.ZERO_IN       = z;
        #1;
        chk("ready", 32'(bus.READY_OUT), 32'(model_ready(s)));
        model_step(inst, v, s, f, z);
        @(negedge clk);
        n_vec++;
        chk("outputs", 32'(dut_word()), 32'(m_exp));
        if (bus.write_OUT) n_wr++;
    endtask

    task automatic do_reset();
        bus.INST_IN       = '0;
        bus.INST_VALID_IN = 1'b0;
        bus.STALL_IN      = 1'b0;
        bus.FLUSH_IN      = 1'b0;
        bus.ZERO_IN       = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(dut_word()), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        m_halt  = 1'b0;
        m_ld_rd = -1;
        m_exp   = '0;
        #1;
        chk("ready_after_reset", 32'(bus.READY_OUT), 32'd1);
    endtask

    initial begin
        int w0;
        rst               = 1'b1;
        bus.INST_IN       = '0;
        bus.INST_VALID_IN = 1'b0;
        bus.STALL_IN      = 1'b0;
        bus.FLUSH_IN      = 1'b0;
        bus.ZERO_IN       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(dut_word()), 32'd0);
        chk("reset_ready", 32'(bus.READY_OUT), 32'd1);
        rst = 1'b0;

        // ADD r3,r1,r2
        cycle(16'h1650, 1, 0, 0, 0);
        chk("add_arbr", {30'd0, bus.AR_OUT, bus.BR_OUT}, 32'd3);
        chk("add_alu", 32'(bus.ALU_OUT), 32'd1);
        chk("add_write", 32'(bus.write_OUT), 32'd1);
        chk("add_wad", 32'(bus.writeAd_OUT), 32'd3);
        chk("add_valid", 32'(bus.VALID_OUT), 32'd1);

        // LD r5: address cycle, write-back cycle, then ready again
        cycle(16'h9A00, 1, 0, 0, 0);
        chk("ld1_adr", 32'(bus.ADR_MUX_OUT), 32'd1);
        chk("ld1_write", 32'(bus.write_OUT), 32'd0);
        chk("ld1_ready", 32'(bus.READY_OUT), 32'd0);
        cycle(16'h0000, 0, 0, 0, 0);
        chk("ld2_write", 32'(bus.write_OUT), 32'd1);
        chk("ld2_wad", 32'(bus.writeAd_OUT), 32'd5);
        cycle(16'h0000, 0, 0, 0, 0);
        chk("ld3_ready", 32'(bus.READY_OUT), 32'd1);

        // BEQ taken / not taken
        cycle(16'hC000, 1, 0, 0, 1);
        chk("beq_taken", 32'(bus.PC_load_OUT), 32'd1);
        cycle(16'hC000, 1, 0, 0, 0);
        chk("beq_not_taken", 32'(bus.PC_load_OUT), 32'd0);

        // LD r2 stalled three cycles in LDWAIT: one write after release
        w0 = n_wr;
        cycle(16'h9400, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(16'h1650, 1, 1, 0, 0);
            chk("stall_frozen_adr", 32'(bus.ADR_MUX_OUT), 32'd1);
        end
        cycle(16'h0000, 0, 0, 0, 0);
        chk("stall_release_wad", 32'(bus.writeAd_OUT), 32'd2);
        cycle(16'h0000, 0, 0, 0, 0);
        chk("stall_write_count", 32'(n_wr - w0), 32'd1);

        // LD r7 flushed in LDWAIT: write never asserted
        w0 = n_wr;
        cycle(16'h9E00, 1, 0, 0, 0);
        cycle(16'h0000, 0, 0, 1, 0);
        chk("flush_valid", 32'(bus.VALID_OUT), 32'd0);
        chk("flush_ready", 32'(bus.READY_OUT), 32'd1);
        cycle(16'h0000, 0, 0, 0, 0);
        chk("flush_write_count", 32'(n_wr - w0), 32'd0);

        // Illegal opcode pulses, also not repeated under stall
        cycle(16'hF000, 1, 0, 0, 0);
        chk("ill_pulse", 32'(bus.ILLEGAL_OUT), 32'd1);
        cycle(16'h0000, 0, 0, 0, 0);
        chk("ill_gone", 32'(bus.ILLEGAL_OUT), 32'd0);
        cycle(16'hD000, 1, 0, 0, 0);
        cycle(16'h0000, 0, 1, 0, 0);
        chk("ill_stall_gone", 32'(bus.ILLEGAL_OUT), 32'd0);
        cycle(16'h0000, 0, 0, 0, 0);

        // Reset during LDWAIT cancels the write
        w0 = n_wr;
        cycle(16'h9200, 1, 0, 0, 0);
        do_reset();
        cycle(16'h0000, 0, 0, 0, 0);
        chk("rst_ld_write_count", 32'(n_wr - w0), 32'd0);

        // HLT sticks until reset
        cycle(16'hE000, 1, 0, 0, 0);
        chk("hlt_halted", 32'(bus.HALTED_OUT), 32'd1);
        for (int k = 0; k < 10; k++) begin
            cycle(16'h1650, 1, 0, k == 4, 0);
            chk("hlt_ready", 32'(bus.READY_OUT), 32'd0);
        end
        do_reset();
        chk("hlt_cleared", 32'(bus.HALTED_OUT), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] inst;
            bit v, s, f, z;
            inst = 16'($urandom);
            v    = ($urandom_range(0, 9) < 7);
            s    = ($urandom_range(0, 9) < 2);
            f    = ($urandom_range(0, 19) == 0);
            z    = 1'($urandom);
            if (f) v = 1'b0;
            if (m_halt && $urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                cycle(inst, v, s, f, z);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
